// File: rtl/bmp_pkg.sv
// BMP stream package: FSM states, BMP header constants and header word builder.
// Shared by the slave-side producer (bmp_slave_tx) and the scheduler side (BMP_OFF_BITS).
// hdr_word() returns one little-endian 32-bit word of the 56-byte padded header.
package bmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HDR,
    ST_PIX,
    ST_DONE
  } state_t;

  localparam int BMP_HDR_BYTES = 54;
  localparam int BMP_OFF_BITS  = 56;  // 54-byte header + 2 pad bytes
  localparam int BMP_HDR_WORDS = 14;
  localparam int BMP_INFO_SIZE = 40;
  localparam int BMP_BPP       = 24;

  // Word k holds header bytes 4k..4k+3, byte 4k in bits [7:0].
  // Fields straddle word boundaries at 16-bit offsets, so each word is
  // built from the upper half of one field and the lower half of the next.
  // Offset, info size and the 12-bit width/height have zero upper halves.
  function automatic logic [31:0] hdr_word(
    input logic [3:0]  index,
    input logic [31:0] file_size,
    input logic [11:0] width,
    input logic [11:0] height,
    input logic [25:0] img_bytes,
    input logic [31:0] xppm,
    input logic [31:0] yppm
  );
    logic [31:0] img32;
    logic [31:0] w;
    img32 = {6'd0, img_bytes};
    case (index)
      4'd0:    w = {file_size[15:0], 16'h4D42};          // "BM", size lo
      4'd1:    w = {16'h0000, file_size[31:16]};         // size hi, reserved
      4'd2:    w = {16'(BMP_OFF_BITS), 16'h0000};        // reserved, offset lo
      4'd3:    w = {16'(BMP_INFO_SIZE), 16'h0000};       // offset hi, info lo
      4'd4:    w = {4'h0, width, 16'h0000};              // info hi, width lo
      4'd5:    w = {4'h0, height, 16'h0000};             // width hi, height lo
      4'd6:    w = {16'd1, 16'h0000};                    // height hi, planes
      4'd7:    w = {16'h0000, 16'(BMP_BPP)};             // bpp, compression lo
      4'd8:    w = {img32[15:0], 16'h0000};              // compression hi, img lo
      4'd9:    w = {xppm[15:0], img32[31:16]};           // img hi, xppm lo
      4'd10:   w = {yppm[15:0], xppm[31:16]};            // xppm hi, yppm lo
      4'd11:   w = {16'h0000, yppm[31:16]};              // yppm hi, colours lo
      default: w = '0;                                   // colours, pad
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bmp_out_slot.sv
// Single registered word slot between the producer and the scheduler slave port.
// Latency: 1 cycle from load to out_valid; full throughput (load while draining).
// Backpressure: out_data held stable while out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Ports: clk, rst_n; in_valid/in_ready/in_data (load side); out_valid/out_ready/out_data (port side).
module bmp_out_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bmp_slave_tx.sv
// Streams one BMP image per start: 14-word generated header, then pixel words from the source.
// Latency: header word 0 valid 2 cycles after start; one word per cycle when unblocked.
// Backpressure: slv_ready low freezes state, counters and slv_data; src_ready follows slot space.
// Ports: start/cfg_* (request), src_* (pixel source), slv_* (scheduler slave port), busy/done/err.
module bmp_slave_tx
  import bmp_pkg::*;
#(
  parameter int DATA_BUS_SIZE = 32,
  parameter int XPPM          = 2835,
  parameter int YPPM          = 2835
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               cfg_mode,
  input  logic [7:0]               cfg_data_proc,
  input  logic [11:0]              cfg_width,
  input  logic [11:0]              cfg_height,
  input  logic [DATA_BUS_SIZE-1:0] src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [1:0]               slv_mode,
  output logic                     slv_data_valid,
  output logic [DATA_BUS_SIZE-1:0] slv_data,
  output logic [7:0]               slv_data_proc,
  input  logic                     slv_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_t state, state_nxt;

  logic [1:0]  mode_r;
  logic [7:0]  dp_r;
  logic [11:0] width_r;
  logic [11:0] height_r;

  logic [13:0] stride;
  logic [25:0] img_bytes;
  logic [31:0] file_size;
  logic [23:0] pix_words;

  logic [3:0]  hdr_idx;
  logic [23:0] pulled;
  logic [23:0] sent;
  logic        slot_is_pix;   // word currently in the slot is a pixel word
  logic        err_q;

  logic                     slot_in_valid;
  logic                     slot_in_ready;
  logic [DATA_BUS_SIZE-1:0] slot_in_data;
  logic                     slot_load;
  logic                     slv_hs;
  logic                     cfg_ok;
  logic                     more_pix;

  assign cfg_ok = (cfg_width != 12'd0) && (cfg_height != 12'd0) &&
                  ((cfg_mode == 2'b01) || (cfg_mode == 2'b10));

  // Derived from the latched config, so stable from SETUP onward.
  // Rows are padded to 4 bytes, so pix_words is an exact division.
  assign stride    = (({2'b00, width_r} * 14'd3) + 14'd3) & ~14'd3;
  assign img_bytes = {12'd0, stride} * {14'd0, height_r};
  assign file_size = {6'd0, img_bytes} + 32'(BMP_OFF_BITS);
  assign pix_words = img_bytes[25:2];

  assign more_pix  = (pulled < pix_words);
  assign slot_load = slot_in_valid && slot_in_ready;
  assign slv_hs    = slv_data_valid && slv_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    slot_in_valid = 1'b0;
    slot_in_data  = '0;
    src_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && cfg_ok) state_nxt = ST_SETUP;
      end
      ST_SETUP, ST_HDR: begin
        slot_in_valid = 1'b1;
        slot_in_data  = hdr_word(hdr_idx, file_size, width_r, height_r, img_bytes,
                                 32'(XPPM), 32'(YPPM));
        if (slot_load) begin
          if (state == ST_SETUP)
            state_nxt = ST_HDR;
          else if (hdr_idx == 4'(BMP_HDR_WORDS - 1))
            state_nxt = ST_PIX;
        end
      end
      ST_PIX: begin
        src_ready     = more_pix && slot_in_ready;
        slot_in_valid = src_valid && more_pix;
        slot_in_data  = src_data;
        // Finish on the handshake of the last pixel word, not on its pull.
        if (slv_hs && slot_is_pix && ((sent + 24'd1) == pix_words))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= 2'b00;
      dp_r        <= 8'd0;
      width_r     <= 12'd0;
      height_r    <= 12'd0;
      hdr_idx     <= 4'd0;
      pulled      <= 24'd0;
      sent        <= 24'd0;
      slot_is_pix <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && start && !cfg_ok;
      // Config is captured at the accepting start edge so it is already
      // frozen during SETUP; later cfg changes cannot leak in.
      if ((state == ST_IDLE) && start && cfg_ok) begin
        mode_r   <= cfg_mode;
        dp_r     <= cfg_data_proc;
        width_r  <= cfg_width;
        height_r <= cfg_height;
        hdr_idx  <= 4'd0;
        pulled   <= 24'd0;
        sent     <= 24'd0;
      end
      if (slot_load) begin
        slot_is_pix <= (state == ST_PIX);
        if ((state == ST_SETUP) || (state == ST_HDR)) hdr_idx <= hdr_idx + 4'd1;
      end
      if ((state == ST_PIX) && src_valid && src_ready) pulled <= pulled + 24'd1;
      if ((state == ST_PIX) && slv_hs && slot_is_pix)  sent   <= sent + 24'd1;
    end
  end

  bmp_out_slot #(.W(DATA_BUS_SIZE)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (slot_in_valid),
    .in_ready  (slot_in_ready),
    .in_data   (slot_in_data),
    .out_valid (slv_data_valid),
    .out_ready (slv_ready),
    .out_data  (slv_data)
  );

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign err           = err_q;
  assign slv_mode      = busy ? mode_r : 2'b00;
  assign slv_data_proc = busy ? dp_r : 8'd0;

endmodule

// File: tb/tb_bmp_slave_tx.sv
// Directed bench for bmp_slave_tx with an expected-word scoreboard.
// Header words come from a byte-level model of the BMP layout; pixels from a counting source.
// Checks: reset, timing, hold-under-backpressure, source gaps, illegal start, mid-image reset.
module tb_bmp_slave_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_data_proc;
  logic [11:0] cfg_width;
  logic [11:0] cfg_height;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [1:0]  slv_mode;
  logic        slv_data_valid;
  logic [31:0] slv_data;
  logic [7:0]  slv_data_proc;
  logic        slv_ready;
  logic        busy;
  logic        done;
  logic        err;

  bmp_slave_tx #(.DATA_BUS_SIZE(32), .XPPM(2835), .YPPM(2835)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_data_proc(cfg_data_proc), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .slv_mode(slv_mode), .slv_data_valid(slv_data_valid), .slv_data(slv_data),
    .slv_data_proc(slv_data_proc), .slv_ready(slv_ready), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  exp_mode = 2'b00;
  logic [7:0]  exp_dp   = 8'd0;
  int          img_tag  = 0;
  int          gap      = 0;
  bit          rdy_toggle = 1'b0;
  int          t0 = 0;

  // Monitor-owned
  int          words_seen = 0;
  int          pix_sent   = 0;
  int          bubbles    = 0;
  bit          done_seen  = 1'b0;
  int          done_cyc   = 0;
  bit          held_pending = 1'b0;
  logic [31:0] held_data  = '0;

  // Driver-owned
  int          pulled_cnt = 0;
  int          src_idx    = 0;
  int          gapcnt     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pix_val(input int tag, input int i);
    return 32'((tag << 24) ^ 32'h00A5_0000 ^ i);
  endfunction

  // Byte-level model of the padded 56-byte header, then the pixel stream.
  task automatic push_image(input int w, input int h, input int tag);
    logic [7:0] b [56];
    int stride, img, fs;
    stride = ((3 * w + 3) / 4) * 4;
    img    = stride * h;
    fs     = img + 56;
    for (int i = 0; i < 56; i++) b[i] = 8'h00;
    b[0] = 8'h42;
    b[1] = 8'h4D;
    for (int k = 0; k < 4; k++) begin
      b[2 + k]  = 8'(fs >> (8 * k));
      b[10 + k] = 8'(56 >> (8 * k));
      b[14 + k] = 8'(40 >> (8 * k));
      b[18 + k] = 8'(w >> (8 * k));
      b[22 + k] = 8'(h >> (8 * k));
      b[34 + k] = 8'(img >> (8 * k));
      b[38 + k] = 8'(2835 >> (8 * k));
      b[42 + k] = 8'(2835 >> (8 * k));
    end
    b[26] = 8'd1;
    b[28] = 8'd24;
    for (int i = 0; i < 14; i++)
      exp_q.push_back({b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
    for (int i = 0; i < img / 4; i++)
      exp_q.push_back(pix_val(tag, i));
  endtask

  // Called at posedge+1; start is high for the cycle numbered t0.
  task automatic start_img(input int w, input int h, input logic [1:0] m,
                           input logic [7:0] dp, input int tag, input bit legal);
    img_tag       = tag;
    cfg_width     = 12'(w);
    cfg_height    = 12'(h);
    cfg_mode      = m;
    cfg_data_proc = dp;
    exp_mode      = m;
    exp_dp        = dp;
    if (legal) push_image(w, h, tag);
    start = 1'b1;
    t0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_seen) break;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pixel source and slave-ready driver.
  initial begin
    bit acc, restart;
    src_valid = 1'b1;
    src_data  = pix_val(0, 0);
    slv_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc     = src_valid && src_ready && rst_n;
      restart = start && !busy;
      @(posedge clk); #1;
      if (restart) begin
        src_idx = 0; src_data = pix_val(img_tag, 0); src_valid = 1'b1;
        gapcnt = 0; pulled_cnt = 0;
      end else if (acc) begin
        pulled_cnt++;
        src_idx++;
        src_data = pix_val(img_tag, src_idx);
        if (gap > 0) begin src_valid = 1'b0; gapcnt = gap; end
      end else if (gapcnt > 0) begin
        gapcnt--;
        if (gapcnt == 0) src_valid = 1'b1;
      end
      slv_ready = rdy_toggle ? !slv_ready : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, hold stability, latched mode/data_proc.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      held_pending = 1'b0; words_seen = 0; pix_sent = 0; bubbles = 0; done_seen = 1'b0;
    end else begin
      if (start && !busy) begin
        words_seen = 0; pix_sent = 0; bubbles = 0; done_seen = 1'b0;
      end
      if (held_pending) begin
        chk("valid_held", 32'(slv_data_valid), 32'd1);
        chk("data_held", slv_data, held_data);
      end
      if (busy && !slv_data_valid && words_seen >= 14 && !done) bubbles++;
      if (slv_data_valid && slv_ready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("word%0d", words_seen), slv_data, e);
        end
        if (words_seen >= 14) pix_sent++;
        words_seen++;
        held_pending = 1'b0;
      end else if (slv_data_valid) begin
        held_pending = 1'b1;
        held_data    = slv_data;
      end else begin
        held_pending = 1'b0;
      end
      if (busy) begin
        chk("slv_mode", 32'(slv_mode), 32'(exp_mode));
        chk("slv_data_proc", 32'(slv_data_proc), 32'(exp_dp));
      end
      if (done) begin done_seen = 1'b1; done_cyc = cyc; end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_mode = 2'b00; cfg_data_proc = 8'd0;
    cfg_width = 12'd0; cfg_height = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(slv_data_valid), 32'd0);
    chk("rst_data", slv_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_mode", 32'(slv_mode), 32'd0);
    chk("rst_dp", 32'(slv_data_proc), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2, mode 01, ready high; a second start and cfg change mid-image are ignored.
    start_img(2, 2, 2'b01, 8'h11, 1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    cfg_width = 12'd7; cfg_mode = 2'b10; cfg_data_proc = 8'hEE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    chk("t1_done_cycle", 32'(done_cyc - t0), 32'd20);
    chk("t1_pulled", 32'(pulled_cnt), 32'd4);
    chk("t1_sent", 32'(pix_sent), 32'd4);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_idle_valid", 32'(slv_data_valid), 32'd0);

    // 1x1, mode 10, data_proc 5A.
    start_img(1, 1, 2'b10, 8'h5A, 2, 1'b1);
    wait_done(200);
    chk("t2_done_cycle", 32'(done_cyc - t0), 32'd17);
    chk("t2_mode_after", 32'(slv_mode), 32'd0);
    chk("t2_dp_after", 32'(slv_data_proc), 32'd0);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_sent", 32'(pix_sent), 32'd1);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 2x2 with slv_ready toggling every cycle.
    rdy_toggle = 1'b1;
    start_img(2, 2, 2'b01, 8'h33, 3, 1'b1);
    wait_done(400);
    rdy_toggle = 1'b0;
    chk("t3_words", 32'(words_seen), 32'd18);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // 2x2 with 3-cycle source gaps after each pixel word.
    gap = 3;
    start_img(2, 2, 2'b10, 8'h44, 4, 1'b1);
    wait_done(400);
    gap = 0;
    chk("t4_bubbles", 32'(bubbles), 32'd9);
    chk("t4_pulled", 32'(pulled_cnt), 32'd4);
    chk("t4_sent", 32'(pix_sent), 32'd4);
    chk("t4_done_cycle", 32'(done_cyc - t0), 32'd29);

    // Illegal starts: width 0, then mode 11.
    start_img(0, 2, 2'b01, 8'h00, 5, 1'b0);
    chk("t5_err_pulse", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("t5_err_clear", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_no_valid", 32'(slv_data_valid), 32'd0);
      chk("t5_no_busy", 32'(busy), 32'd0);
    end
    start_img(2, 2, 2'b11, 8'h00, 5, 1'b0);
    chk("t5_err_mode11", 32'(err), 32'd1);
    chk("t5_busy_mode11", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Reset while header word 7 is on the bus, then a fresh image.
    start_img(2, 2, 2'b01, 8'h66, 6, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (words_seen == 7) break;
      @(posedge clk); #1;
    end
    chk("t6_at_word7", 32'(words_seen), 32'd7);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(slv_data_valid), 32'd0);
    chk("t6_rst_data", slv_data, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_mode", 32'(slv_mode), 32'd0);
    chk("t6_rst_src_ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_img(2, 2, 2'b01, 8'h77, 7, 1'b1);
    wait_done(200);
    chk("t6_words", 32'(words_seen), 32'd18);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_done_cycle", 32'(done_cyc - t0), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
